// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity mode and frame-check state.
package uart_pkg;

  // Encoding matches the par_typ input field.
  typedef enum logic [1:0] {
    ParEven  = 2'd0,
    ParOdd   = 2'd1,
    ParMark  = 2'd2,
    ParSpace = 2'd3
  } par_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_t;

endpackage

// File: rtl/par_calc.sv
// Running XOR over received data bits plus selection of the expected parity bit.
module par_calc
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear_i,
  input  logic      bit_en_i,
  input  logic      bit_i,
  input  par_mode_t mode_i,
  output logic      exp_bit_o
);

  logic xor_q, xor_d;

  // Next running parity: clear at frame start, accumulate each accepted data bit.
  always_comb begin
    xor_d = xor_q;
    if (clear_i) begin
      xor_d = 1'b0;
    end else if (bit_en_i) begin
      xor_d = xor_q ^ bit_i;
    end
  end

  // Running parity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
    end
  end

  // Expected parity bit for the selected mode.
  always_comb begin
    exp_bit_o = 1'b0;
    unique case (mode_i)
      ParEven:  exp_bit_o = xor_q;
      ParOdd:   exp_bit_o = ~xor_q;
      ParMark:  exp_bit_o = 1'b1;
      ParSpace: exp_bit_o = 1'b0;
      default:  exp_bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame assembler: collects data bits, checks parity and stop bits,
// and pulses data_valid once per completed frame.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_det,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic [1:0]            par_typ,
  input  logic                  stop2,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  // Counter value seen on the bit_valid that completes the data field.
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  rx_state_t             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  valid_q, valid_d;
  logic                  par_en_q, par_en_d;
  par_mode_t             par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;

  logic par_clear;
  logic par_shift;
  logic par_exp;

  par_calc u_par_calc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (par_clear),
    .bit_en_i  (par_shift),
    .bit_i     (sampled_bit),
    .mode_i    (par_typ_q),
    .exp_bit_o (par_exp)
  );

  // Frame FSM next-state, data path updates and completion pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    valid_d    = 1'b0;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    par_clear  = 1'b0;
    par_shift  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_det) begin
          par_en_d   = par_en;
          par_typ_d  = par_mode_t'(par_typ);
          stop2_d    = stop2;
          cnt_d      = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
          par_clear  = 1'b1;
          state_d    = StData;
        end
      end
      StData: begin
        if (bit_valid) begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          par_shift = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = par_en_q ? StParity : StStop1;
          end
        end
      end
      StParity: begin
        if (bit_valid) begin
          par_err_d = (sampled_bit != par_exp);
          state_d   = StStop1;
        end
      end
      StStop1: begin
        if (bit_valid) begin
          if (!sampled_bit) begin
            stop_err_d = 1'b1;
          end
          if (stop2_q) begin
            state_d = StStop2;
          end else begin
            state_d = StIdle;
            valid_d = 1'b1;
          end
        end
      end
      StStop2: begin
        if (bit_valid) begin
          if (!sampled_bit) begin
            stop_err_d = 1'b1;
          end
          state_d = StIdle;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      valid_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= ParEven;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      valid_q    <= valid_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
    end
  end

  // The shift register only moves after an accepted start, so it doubles as the
  // held output word.
  always_comb begin
    data_out   = shift_q;
    data_valid = valid_q;
    par_err    = par_err_q;
    stop_err   = stop_err_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check with 8-bit and 7-bit instances.
module tb_uart_rx_frame_check;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_det = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       par_en = 1'b0;
  logic [1:0] par_typ = 2'd0;
  logic       stop2 = 1'b0;

  logic [7:0] do8;
  logic       dv8, pe8, se8, busy8;
  logic [6:0] do7;
  logic       dv7, pe7, se7, busy7;

  int checks = 0;
  int errors = 0;
  int cnt8 = 0;
  int cnt7 = 0;

  always #5 clk = ~clk;

  uart_rx_frame_check #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_det(start_det), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .data_out(do8), .data_valid(dv8), .par_err(pe8), .stop_err(se8), .busy(busy8)
  );

  uart_rx_frame_check #(.DATA_WIDTH(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .start_det(start_det), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .data_out(do7), .data_valid(dv7), .par_err(pe7), .stop_err(se7), .busy(busy7)
  );

  // Count data_valid cycles just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (dv8) cnt8++;
    if (dv7) cnt7++;
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start_det = 1'b1;
    @(negedge clk); start_det = 1'b0;
  endtask

  // Returns at the negedge after the bit was registered.
  task automatic send_bit(input logic b);
    @(negedge clk); sampled_bit = b; bit_valid = 1'b1;
    @(negedge clk); bit_valid = 1'b0; sampled_bit = 1'b0;
  endtask

  task automatic send_data(input logic [8:0] d, input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_bit(d[i]);
  endtask

  task automatic send_frame8(input logic [7:0] d, input logic has_par, input logic pbit,
                             input logic s1);
    pulse_start();
    send_data({1'b0, d}, 0, 8);
    if (has_par) send_bit(pbit);
    send_bit(s1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (do8 !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", do8); end
    checks++; if (dv8 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", dv8); end
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL rst_par_err got %b want 0", pe8); end
    checks++; if (se8 !== 1'b0) begin errors++; $display("FAIL rst_stop_err got %b want 0", se8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy8); end
    checks++; if (do7 !== 7'h00) begin errors++; $display("FAIL rst_data7 got %h want 00", do7); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_even();
    int base;
    par_en = 1'b1; par_typ = 2'd0; stop2 = 1'b0;
    base = cnt8;
    send_frame8(8'hA5, 1'b1, 1'b0, 1'b1);
    checks++; if (dv8 !== 1'b1) begin errors++; $display("FAIL even_valid got %b want 1", dv8); end
    checks++; if (do8 !== 8'hA5) begin errors++; $display("FAIL even_data got %h want a5", do8); end
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL even_par_err got %b want 0", pe8); end
    checks++; if (se8 !== 1'b0) begin errors++; $display("FAIL even_stop_err got %b want 0", se8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL even_busy got %b want 0", busy8); end
    // bit_valid while idle must not disturb the held word.
    send_bit(1'b0);
    send_bit(1'b1);
    checks++; if (cnt8 - base !== 1) begin errors++; $display("FAIL even_pulses got %0d want 1", cnt8 - base); end
    checks++; if (do8 !== 8'hA5) begin errors++; $display("FAIL even_hold got %h want a5", do8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL even_idle_busy got %b want 0", busy8); end
  endtask

  task automatic test_odd();
    par_en = 1'b1; par_typ = 2'd1; stop2 = 1'b0;
    send_frame8(8'hA5, 1'b1, 1'b0, 1'b1);
    checks++; if (pe8 !== 1'b1) begin errors++; $display("FAIL odd_a5_par_err got %b want 1", pe8); end
    send_frame8(8'h01, 1'b1, 1'b0, 1'b1);
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL odd_01_par_err got %b want 0", pe8); end
    checks++; if (do8 !== 8'h01) begin errors++; $display("FAIL odd_01_data got %h want 01", do8); end
  endtask

  task automatic test_width7();
    int base;
    do_reset();
    par_en = 1'b0; par_typ = 2'd0; stop2 = 1'b1;
    base = cnt7;
    pulse_start();
    send_data(9'h055, 0, 7);
    send_bit(1'b1);
    checks++; if (cnt7 - base !== 0) begin errors++; $display("FAIL w7_early_valid got %0d want 0", cnt7 - base); end
    checks++; if (busy7 !== 1'b1) begin errors++; $display("FAIL w7_busy got %b want 1", busy7); end
    send_bit(1'b0);
    checks++; if (dv7 !== 1'b1) begin errors++; $display("FAIL w7_valid got %b want 1", dv7); end
    checks++; if (do7 !== 7'h55) begin errors++; $display("FAIL w7_data got %h want 55", do7); end
    checks++; if (se7 !== 1'b1) begin errors++; $display("FAIL w7_stop_err got %b want 1", se7); end
    checks++; if (pe7 !== 1'b0) begin errors++; $display("FAIL w7_par_err got %b want 0", pe7); end
    @(negedge clk);
    checks++; if (cnt7 - base !== 1) begin errors++; $display("FAIL w7_pulses got %0d want 1", cnt7 - base); end
  endtask

  task automatic test_mark_space();
    do_reset();
    par_en = 1'b1; stop2 = 1'b0;
    par_typ = 2'd2;
    send_frame8(8'h00, 1'b1, 1'b1, 1'b1);
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL mark_ok got %b want 0", pe8); end
    send_frame8(8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (pe8 !== 1'b1) begin errors++; $display("FAIL mark_bad got %b want 1", pe8); end
    par_typ = 2'd3;
    send_frame8(8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL space_ok got %b want 0", pe8); end
    send_frame8(8'h00, 1'b1, 1'b1, 1'b1);
    checks++; if (pe8 !== 1'b1) begin errors++; $display("FAIL space_bad got %b want 1", pe8); end
  endtask

  task automatic test_reset_abort();
    int base;
    par_en = 1'b1; par_typ = 2'd0; stop2 = 1'b0;
    base = cnt8;
    pulse_start();
    send_data(9'h03C, 0, 4);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy8); end
    checks++; if (do8 !== 8'h00) begin errors++; $display("FAIL abort_data got %h want 00", do8); end
    rst_n = 1'b1;
    @(negedge clk);
    send_frame8(8'h3C, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (cnt8 - base !== 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", cnt8 - base); end
    checks++; if (do8 !== 8'h3C) begin errors++; $display("FAIL abort_data_3c got %h want 3c", do8); end
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL abort_par_err got %b want 0", pe8); end
  endtask

  task automatic test_back_to_back();
    par_en = 1'b1; par_typ = 2'd0; stop2 = 1'b0;
    pulse_start();
    send_data(9'h0A5, 0, 3);
    pulse_start();
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid got %b want 1", busy8); end
    par_typ = 2'd1;
    send_data(9'h0A5, 3, 8);
    send_bit(1'b0);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_busy_stop got %b want 1", busy8); end
    send_bit(1'b1);
    checks++; if (dv8 !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", dv8); end
    checks++; if (do8 !== 8'hA5) begin errors++; $display("FAIL b2b_data got %h want a5", do8); end
    checks++; if (pe8 !== 1'b0) begin errors++; $display("FAIL b2b_par_err got %b want 0", pe8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy8); end
    // Stop error on one frame, then a clean frame must clear it.
    par_typ = 2'd0;
    send_frame8(8'h5A, 1'b1, 1'b0, 1'b0);
    checks++; if (se8 !== 1'b1) begin errors++; $display("FAIL b2b_stop_err got %b want 1", se8); end
    checks++; if (do8 !== 8'h5A) begin errors++; $display("FAIL b2b_data_5a got %h want 5a", do8); end
    send_frame8(8'hC3, 1'b1, 1'b0, 1'b1);
    checks++; if (se8 !== 1'b0) begin errors++; $display("FAIL b2b_stop_clr got %b want 0", se8); end
    checks++; if (do8 !== 8'hC3) begin errors++; $display("FAIL b2b_data_c3 got %h want c3", do8); end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_width7();
    test_mark_space();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_check.md
UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame; legal range 5..9.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_det  input  1  one-cycle pulse: a valid start bit has been detected.
REQ-005 SHALL have port bit_valid  input  1  one-cycle strobe: sampled_bit holds the mid-bit sample of the next frame bit.
REQ-006 SHALL have port sampled_bit  input  1  the sampled serial bit, qualified by bit_valid.
REQ-007 SHALL have port par_en  input  1  1 = the frame carries a parity bit.
REQ-008 SHALL have port par_typ  input  2  parity mode of type par_mode_t: EVEN=0, ODD=1, MARK=2, SPACE=3.
REQ-009 SHALL have port stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  received data word, LSB first on the line.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse: the frame is complete.
REQ-012 SHALL have port par_err  output  1  1 = parity mismatch.
REQ-013 SHALL have port stop_err  output  1  1 = a stop bit was sampled as 0.
REQ-014 SHALL have port busy  output  1  1 = a frame is in progress (state not IDLE).

Function
REQ-015 SHALL implement the states IDLE, DATA, PARITY, STOP1, STOP2.
REQ-016 In IDLE, a start_det pulse SHALL latch par_en, par_typ and stop2, clear the bit counter, running parity, par_err and stop_err, and move to DATA on the next edge.
REQ-017 start_det SHALL be ignored outside IDLE, and bit_valid SHALL be ignored in IDLE.
REQ-018 In DATA, each bit_valid SHALL shift sampled_bit into the MSB of the shift register, XOR it into the running parity, and increment a counter of width $clog2(DATA_WIDTH+1).
REQ-019 When the counter reaches DATA_WIDTH on a bit_valid, the block SHALL go to PARITY if the latched par_en is 1, otherwise to STOP1.
REQ-020 In PARITY, on bit_valid the expected bit SHALL be: EVEN = running XOR; ODD = inverted running XOR; MARK = 1; SPACE = 0. par_err SHALL be set to (sampled_bit != expected), and the state SHALL go to STOP1.
REQ-021 In STOP1, on bit_valid, stop_err SHALL be set if sampled_bit = 0; the state SHALL go to STOP2 if the latched stop2 is 1, otherwise to IDLE.
REQ-022 In STOP2, on bit_valid, stop_err SHALL be set if sampled_bit = 0 (OR-ed with any STOP1 error), and the state SHALL go to IDLE.
REQ-023 data_valid SHALL pulse for exactly one cycle, in the cycle after the edge on which the final stop bit's bit_valid is registered; data_out, par_err and stop_err SHALL be updated no later than that cycle.
REQ-024 data_out, par_err and stop_err SHALL hold their values until the next accepted start_det.
REQ-025 par_err SHALL remain 0 when the latched par_en is 0.
REQ-026 Changes to par_en, par_typ or stop2 mid-frame SHALL have no effect until the next frame.

Reset
REQ-027 While rst_n = 0, the block SHALL be in state IDLE, with the counter, shift register and running parity at 0.
REQ-028 While rst_n = 0, the outputs SHALL be data_out = 0, data_valid = 0, par_err = 0, stop_err = 0, busy = 0.
REQ-029 A reset asserted mid-frame SHALL abort the frame without a data_valid pulse; the first start_det after release SHALL start a clean frame.

Structure
REQ-030 par_mode_t and the state enum SHALL be defined in the shared package uart_pkg.
REQ-031 The parity-expectation logic SHALL be a sub-module par_calc (running XOR plus mode select); all other logic SHALL live in uart_rx_frame_check.

Verification
REQ-032 DATA_WIDTH=8, EVEN, one stop bit, data 0xA5, parity bit 0, stop bit 1 -> data_out = 0xA5, par_err = 0, stop_err = 0, one data_valid pulse.
REQ-033 DATA_WIDTH=8, ODD, data 0xA5, parity bit 0 -> par_err = 1; a following frame with data 0x01, parity bit 0 -> par_err = 0.
REQ-034 DATA_WIDTH=7, par_en = 0, stop2 = 1, data 0x55, stop bits 1 then 0 -> data_out = 0x55, stop_err = 1, data_valid appears only after the second stop bit.
REQ-035 MARK and SPACE modes, data 0x00, parity bits 1 and 0 respectively -> par_err = 0; inverted parity bits -> par_err = 1.
REQ-036 rst_n pulsed low after the 4th data bit, then a full 0x3C EVEN frame -> no data_valid for the aborted frame, then data_out = 0x3C.
REQ-037 Extra start_det pulse during DATA, and a par_typ change mid-frame -> frame result unchanged, busy stays 1 until the final stop bit.
